// File: rtl/cu_pkg.sv
// Shared definitions for the control unit: state encoding, opcodes, ALU and
// branch condition codes, and fixed register-file addresses.
package cu_pkg;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_INCPC = 3'd2,
    S_EXEC  = 3'd3,
    S_MEM   = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  localparam logic [3:0] OP_LD  = 4'h8;
  localparam logic [3:0] OP_ST  = 4'h9;
  localparam logic [3:0] OP_BR  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [3:0] ALU_ADD = 4'h0;

  localparam logic [2:0] COND_AL = 3'd0;
  localparam logic [2:0] COND_Z  = 3'd1;
  localparam logic [2:0] COND_N  = 3'd2;
  localparam logic [2:0] COND_C  = 3'd3;
  localparam logic [2:0] COND_V  = 3'd4;
  localparam logic [2:0] COND_NZ = 3'd5;
  localparam logic [2:0] COND_NN = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  localparam logic [3:0] REG_DISP   = 4'd8;
  localparam logic [3:0] REG_CONST2 = 4'd12;
  localparam logic [3:0] REG_TEMP0  = 4'd13;
  localparam logic [3:0] REG_PC     = 4'd14;
  localparam logic [3:0] REG_IR     = 4'd15;

  function automatic logic is_reserved(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch condition evaluation against ALU flags {n,z,v,c}.
module branch_cond
  import cu_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n, z, v, c;
  assign {n, z, v, c} = flags;

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_AL: taken = 1'b1;
      COND_Z:  taken = z;
      COND_N:  taken = n;
      COND_C:  taken = c;
      COND_V:  taken = v;
      COND_NZ: taken = !z;
      COND_NN: taken = !n;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: fetch / PC increment / execute / memory sequencing.
// Define CU_ILLEGAL_TRAP_EN to halt with illegal=1 on reserved opcodes 0xB-0xE.
module control_unit
  import cu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] ir,
  input  logic [3:0]  flags,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  addrA,
  output logic [3:0]  addrB,
  output logic [3:0]  addrD,
  output logic        rw,
  output logic [3:0]  alu_op,
  output logic        data_sel,
  output logic        halt,
  output logic        illegal
);

  state_t state, state_nx;

  logic [3:0] op;
  logic [2:0] rd, rs1, rs2;
  logic       taken;
  logic       unused_ir;

  assign op        = ir[15:12];
  assign rd        = ir[11:9];
  assign rs1       = ir[8:6];
  assign rs2       = ir[5:3];
  assign unused_ir = ^ir[2:0];

  branch_cond u_branch_cond (
    .cond  (rd),
    .flags (flags),
    .taken (taken)
  );

  always_ff @(posedge clk) begin
    if (!reset) state <= S_INIT;
    else        state <= state_nx;
  end

`ifdef CU_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (!reset)                                  illegal_q <= 1'b0;
    else if (state == S_EXEC && is_reserved(op)) illegal_q <= 1'b1;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    addrA    = '0;
    addrB    = '0;
    addrD    = '0;
    rw       = 1'b0;
    alu_op   = ALU_ADD;
    data_sel = 1'b0;
    halt     = 1'b0;
    case (state)
      S_INIT: state_nx = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        addrA    = REG_PC;
        addrD    = REG_IR;
        data_sel = 1'b1;
        rw       = mem_ready;
        if (mem_ready) state_nx = S_INCPC;
      end
      S_INCPC: begin
        addrA    = REG_PC;
        addrB    = REG_CONST2;
        addrD    = REG_PC;
        rw       = 1'b1;
        state_nx = S_EXEC;
      end
      S_EXEC: begin
        state_nx = S_FETCH;
        if (!op[3]) begin
          alu_op = {1'b0, op[2:0]};
          addrA  = {1'b0, rs1};
          addrB  = {1'b0, rs2};
          addrD  = {1'b0, rd};
          rw     = (rd != 3'd0);
        end else if (op == OP_LD || op == OP_ST) begin
          addrA    = {1'b0, rs1};
          addrB    = {1'b0, rs2};
          addrD    = REG_TEMP0;
          rw       = 1'b1;
          state_nx = S_MEM;
        end else if (op == OP_BR) begin
          addrA = REG_PC;
          addrB = REG_DISP;
          addrD = REG_PC;
          rw    = taken;
        end else if (op == OP_HLT) begin
          state_nx = S_HALT;
        end else begin
`ifdef CU_ILLEGAL_TRAP_EN
          state_nx = S_HALT;
`else
          state_nx = S_FETCH;
`endif
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        addrA   = REG_TEMP0;
        mem_we  = (op == OP_ST);
        if (op == OP_ST) begin
          addrB = {1'b0, rd};
        end else begin
          addrD    = {1'b0, rd};
          data_sel = 1'b1;
          rw       = mem_ready && (rd != 3'd0);
        end
        if (mem_ready) state_nx = S_FETCH;
      end
      S_HALT: halt = 1'b1;
      default: state_nx = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: per-cycle expected output vectors are
// queued as stimulus is applied and compared once the outputs settle.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] ir;
  logic [3:0]  flags;
  logic        mem_ready;
  logic        mem_req, mem_we, rw, data_sel, halt, illegal;
  logic [3:0]  addrA, addrB, addrD, alu_op;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [21:0] sb_q[$];

  control_unit dut (
    .clk       (clk),
    .reset     (reset),
    .ir        (ir),
    .flags     (flags),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .addrA     (addrA),
    .addrB     (addrB),
    .addrD     (addrD),
    .rw        (rw),
    .alu_op    (alu_op),
    .data_sel  (data_sel),
    .halt      (halt),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  // Vector layout: {halt, illegal, mem_req, mem_we, addrA, addrB, addrD, rw, alu_op, data_sel}
  function automatic logic [21:0] vec(input logic mq, input logic we,
                                      input logic [3:0] a, input logic [3:0] b,
                                      input logic [3:0] d, input logic w,
                                      input logic [3:0] alu, input logic ds,
                                      input logic h, input logic il);
    return {h, il, mq, we, a, b, d, w, alu, ds};
  endfunction

  function automatic logic [21:0] v_fetch(input logic rdy);
    return vec(1, 0, 4'd14, 4'd0, 4'd15, rdy, 4'd0, 1, 0, 0);
  endfunction

  function automatic logic [21:0] v_incpc();
    return vec(0, 0, 4'd14, 4'd12, 4'd14, 1, 4'd0, 0, 0, 0);
  endfunction

  task automatic check_eq(input string tag, input logic [21:0] got, input logic [21:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %06h expected %06h", tag, got, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic rst, input logic [15:0] i,
                     input logic [3:0] fl, input logic rdy, input logic [21:0] exp);
    logic [21:0] e;
    @(negedge clk);
    reset     = rst;
    ir        = i;
    flags     = fl;
    mem_ready = rdy;
    sb_q.push_back(exp);
    #2;
    e = sb_q.pop_front();
    check_eq(tag, {halt, illegal, mem_req, mem_we, addrA, addrB, addrD, rw, alu_op, data_sel}, e);
  endtask

  localparam logic [21:0] Z = '0;

  initial begin
    reset = 1'b0; ir = '0; flags = '0; mem_ready = 1'b0;
    @(posedge clk);
    cyc("rst",      0, 16'h0000, 4'h0, 1, Z);
    cyc("init",     1, 16'h0000, 4'h0, 1, Z);

    // ADD r1,r1,r2
    cyc("add_f",    1, 16'h0250, 4'h0, 1, v_fetch(1));
    cyc("add_i",    1, 16'h0250, 4'h0, 1, v_incpc());
    cyc("add_x",    1, 16'h0250, 4'h0, 1, vec(0, 0, 4'd1, 4'd2, 4'd1, 1, 4'd0, 0, 0, 0));

    // op 3 with rd=0, one fetch wait: no write
    cyc("r0_fw",    1, 16'h3050, 4'h0, 0, v_fetch(0));
    cyc("r0_f",     1, 16'h3050, 4'h0, 1, v_fetch(1));
    cyc("r0_i",     1, 16'h3050, 4'h0, 1, v_incpc());
    cyc("r0_x",     1, 16'h3050, 4'h0, 1, vec(0, 0, 4'd1, 4'd2, 4'd0, 0, 4'd3, 0, 0, 0));

    // LD r2,[r1+r2] with three MEM waits
    cyc("ld_f",     1, 16'h8450, 4'h0, 1, v_fetch(1));
    cyc("ld_i",     1, 16'h8450, 4'h0, 1, v_incpc());
    cyc("ld_x",     1, 16'h8450, 4'h0, 1, vec(0, 0, 4'd1, 4'd2, 4'd13, 1, 4'd0, 0, 0, 0));
    for (int i = 0; i < 3; i++)
      cyc("ld_mw",  1, 16'h8450, 4'h0, 0, vec(1, 0, 4'd13, 4'd0, 4'd2, 0, 4'd0, 1, 0, 0));
    cyc("ld_m",     1, 16'h8450, 4'h0, 1, vec(1, 0, 4'd13, 4'd0, 4'd2, 1, 4'd0, 1, 0, 0));

    // BR z taken, then not taken
    cyc("brz_f",    1, 16'hA200, 4'b0100, 1, v_fetch(1));
    cyc("brz_i",    1, 16'hA200, 4'b0100, 1, v_incpc());
    cyc("brz_t",    1, 16'hA200, 4'b0100, 1, vec(0, 0, 4'd14, 4'd8, 4'd14, 1, 4'd0, 0, 0, 0));
    cyc("brz_f2",   1, 16'hA200, 4'b0000, 1, v_fetch(1));
    cyc("brz_i2",   1, 16'hA200, 4'b0000, 1, v_incpc());
    cyc("brz_n",    1, 16'hA200, 4'b0000, 1, vec(0, 0, 4'd14, 4'd8, 4'd14, 0, 4'd0, 0, 0, 0));

    // BR c taken on carry, BR !n not taken with n set
    cyc("brc_f",    1, 16'hA600, 4'b0001, 1, v_fetch(1));
    cyc("brc_i",    1, 16'hA600, 4'b0001, 1, v_incpc());
    cyc("brc_t",    1, 16'hA600, 4'b0001, 1, vec(0, 0, 4'd14, 4'd8, 4'd14, 1, 4'd0, 0, 0, 0));
    cyc("brnn_f",   1, 16'hAC00, 4'b1000, 1, v_fetch(1));
    cyc("brnn_i",   1, 16'hAC00, 4'b1000, 1, v_incpc());
    cyc("brnn_n",   1, 16'hAC00, 4'b1000, 1, vec(0, 0, 4'd14, 4'd8, 4'd14, 0, 4'd0, 0, 0, 0));

    // ST r2 abandoned by reset in the second MEM wait
    cyc("st_f",     1, 16'h9450, 4'h0, 1, v_fetch(1));
    cyc("st_i",     1, 16'h9450, 4'h0, 1, v_incpc());
    cyc("st_x",     1, 16'h9450, 4'h0, 1, vec(0, 0, 4'd1, 4'd2, 4'd13, 1, 4'd0, 0, 0, 0));
    cyc("st_mw1",   1, 16'h9450, 4'h0, 0, vec(1, 1, 4'd13, 4'd2, 4'd0, 0, 4'd0, 0, 0, 0));
    cyc("st_mw2",   0, 16'h9450, 4'h0, 0, vec(1, 1, 4'd13, 4'd2, 4'd0, 0, 4'd0, 0, 0, 0));
    cyc("st_rst",   1, 16'h9450, 4'h0, 0, Z);
    cyc("st_refch", 1, 16'h9450, 4'h0, 0, v_fetch(0));
    cyc("st_ref",   1, 16'h9450, 4'h0, 1, v_fetch(1));
    cyc("st_i2",    1, 16'h9450, 4'h0, 1, v_incpc());
    cyc("st_x2",    1, 16'h9450, 4'h0, 1, vec(0, 0, 4'd1, 4'd2, 4'd13, 1, 4'd0, 0, 0, 0));
    cyc("st_m",     1, 16'h9450, 4'h0, 1, vec(1, 1, 4'd13, 4'd2, 4'd0, 0, 4'd0, 0, 0, 0));

    // Reserved opcode 0xC
    cyc("ill_f",    1, 16'hC000, 4'h0, 1, v_fetch(1));
    cyc("ill_i",    1, 16'hC000, 4'h0, 1, v_incpc());
    cyc("ill_x",    1, 16'hC000, 4'h0, 1, Z);
`ifdef CU_ILLEGAL_TRAP_EN
    cyc("ill_h1",   1, 16'h0250, 4'h0, 1, vec(0, 0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 1));
    cyc("ill_h2",   0, 16'h0250, 4'h0, 1, vec(0, 0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 1));
    cyc("ill_rst",  1, 16'h0250, 4'h0, 1, Z);
`else
    cyc("ill_nop",  1, 16'hC000, 4'h0, 1, v_fetch(1));
    cyc("ill_i2",   1, 16'hC000, 4'h0, 1, v_incpc());
    cyc("ill_x2",   1, 16'hC000, 4'h0, 1, Z);
`endif

    // HALT is sticky until reset
    cyc("hlt_f",    1, 16'hF000, 4'h0, 1, v_fetch(1));
    cyc("hlt_i",    1, 16'hF000, 4'h0, 1, v_incpc());
    cyc("hlt_x",    1, 16'hF000, 4'h0, 1, Z);
    cyc("hlt_h1",   1, 16'h0250, 4'h0, 1, vec(0, 0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 0));
    cyc("hlt_h2",   0, 16'h0250, 4'h0, 1, vec(0, 0, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0, 1, 0));
    cyc("hlt_rst",  1, 16'h0250, 4'h0, 1, Z);
    cyc("hlt_ref",  1, 16'h0250, 4'h0, 1, v_fetch(1));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
